// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART TX framer: start, data LSB first, optional parity, 1/2 stop bits
// One CLK per serial bit; frame content comes only from the copies latched at acceptance.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  par_bit
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic [CW-1:0]         cnt;

  // TX_OUT and Busy are assigned alongside the transition, so they reflect the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      data_q   <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      cnt      <= '0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_q   <= P_DATA;
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2;
            case (PAR_TYP)
              2'b00:   par_bit <= ^P_DATA;
              2'b01:   par_bit <= ~^P_DATA;
              2'b10:   par_bit <= 1'b1;
              default: par_bit <= 1'b0;
            endcase
            state  <= START;
            TX_OUT <= 1'b0;
            Busy   <= 1'b1;
          end
        end
        START: begin
          cnt    <= '0;
          state  <= DATA;
          TX_OUT <= data_q[0];
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            TX_OUT <= data_q[cnt + 1'b1];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          // cnt counts the stop bits already sent when two are requested.
          if (stop2_q && cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            cnt    <= '0;
            state  <= IDLE;
            Busy   <= 1'b0;
            TX_OUT <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          TX_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed and random frames on 8-bit and 5-bit framers
// Expected line bits come from a list-based frame model built from the framing rules.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] p_data = '0;
  logic       dv8 = 1'b0;
  logic       dv5 = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_typ = 2'b00;
  logic       stop2 = 1'b0;
  logic       tx8, busy8, par8;
  logic       tx5, busy5, par5;

  int tests = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data), .Data_Valid(dv8), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2(stop2), .TX_OUT(tx8), .Busy(busy8), .par_bit(par8)
  );

  uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data[4:0]), .Data_Valid(dv5), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2(stop2), .TX_OUT(tx5), .Busy(busy5), .par_bit(par5)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic model_par(input int dw, input logic [7:0] d, input logic [1:0] pt);
    int ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(d[i]);
    case (pt)
      2'b00:   return logic'(ones % 2);
      2'b01:   return logic'(1 - ones % 2);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic build(input int dw, input logic [7:0] d, input logic pe, input logic [1:0] pt,
                       input logic s2, output logic q[$]);
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < dw; i++) q.push_back(d[i]);
    if (pe) q.push_back(model_par(dw, d, pt));
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
  endtask

  function automatic logic obs_tx(input int dw);
    return (dw == 5) ? tx5 : tx8;
  endfunction

  function automatic logic obs_busy(input int dw);
    return (dw == 5) ? busy5 : busy8;
  endfunction

  function automatic logic obs_par(input int dw);
    return (dw == 5) ? par5 : par8;
  endfunction

  // Checks edges N+1 .. N+L; caller has already sampled edge N.
  task automatic check_tail(input string tag, input int dw, input logic q[$]);
    for (int k = 1; k < q.size(); k++) begin
      @(posedge CLK); #1;
      check($sformatf("%s tx bit%0d", tag, k), obs_tx(dw), q[k]);
      check($sformatf("%s busy bit%0d", tag, k), obs_busy(dw), 1'b1);
    end
    @(posedge CLK); #1;
    check({tag, " end busy"}, obs_busy(dw), 1'b0);
    check({tag, " end tx"}, obs_tx(dw), 1'b1);
  endtask

  task automatic run_frame(input string tag, input int dw, input logic [7:0] d, input logic pe,
                           input logic [1:0] pt, input logic s2);
    logic q[$];
    build(dw, d, pe, pt, s2, q);
    @(negedge CLK);
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2;
    if (dw == 5) dv5 = 1'b1; else dv8 = 1'b1;
    @(posedge CLK); #1;
    check({tag, " start tx"}, obs_tx(dw), 1'b0);
    check({tag, " start busy"}, obs_busy(dw), 1'b1);
    check({tag, " par_bit"}, obs_par(dw), model_par(dw, d, pt));
    @(negedge CLK);
    dv5 = 1'b0; dv8 = 1'b0;
    // Scramble inputs: the frame in flight must not notice.
    p_data = 8'($urandom); par_en = 1'($urandom); par_typ = 2'($urandom); stop2 = 1'($urandom);
    check_tail(tag, dw, q);
  endtask

  initial begin
    logic q1[$];
    logic q2[$];

    // Reset state
    #12;
    check("rst tx8", tx8, 1'b1);
    check("rst busy8", busy8, 1'b0);
    check("rst par8", par8, 1'b0);
    check("rst tx5", tx5, 1'b1);
    check("rst busy5", busy5, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    run_frame("even_1stop", 8, 8'hA5, 1'b1, 2'b00, 1'b0);
    run_frame("odd_2stop", 8, 8'hA5, 1'b1, 2'b01, 1'b1);
    run_frame("nopar_2stop", 8, 8'hFF, 1'b0, 2'b00, 1'b1);
    run_frame("mark", 8, 8'h00, 1'b1, 2'b10, 1'b0);
    run_frame("space", 8, 8'hFF, 1'b1, 2'b11, 1'b0);
    run_frame("narrow_odd", 5, 8'h13, 1'b1, 2'b01, 1'b0);

    // Handshake: Data_Valid held high, data changed mid-frame
    build(8, 8'h3C, 1'b1, 2'b00, 1'b0, q1);
    build(8, 8'hC3, 1'b1, 2'b00, 1'b0, q2);
    @(negedge CLK);
    p_data = 8'h3C; par_en = 1'b1; par_typ = 2'b00; stop2 = 1'b0; dv8 = 1'b1;
    @(posedge CLK); #1;
    check("hs1 start tx", tx8, 1'b0);
    check("hs1 par_bit", par8, model_par(8, 8'h3C, 2'b00));
    @(negedge CLK);
    p_data = 8'hC3;
    check_tail("hs1", 8, q1);
    @(posedge CLK); #1;
    check("hs2 start tx", tx8, 1'b0);
    check("hs2 start busy", busy8, 1'b1);
    check("hs2 par_bit", par8, model_par(8, 8'hC3, 2'b00));
    @(negedge CLK);
    dv8 = 1'b0;
    check_tail("hs2", 8, q2);

    // Reset asserted during data bit 3
    @(negedge CLK);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 2'b01; stop2 = 1'b0; dv8 = 1'b1;
    @(posedge CLK); #1;
    check("rmf par_bit before", par8, 1'b1);
    @(negedge CLK);
    dv8 = 1'b0;
    repeat (4) @(posedge CLK);
    #3;
    check("rmf busy before", busy8, 1'b1);
    RST = 1'b0;
    #1;
    check("rmf tx", tx8, 1'b1);
    check("rmf busy", busy8, 1'b0);
    check("rmf par_bit", par8, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rmf idle tx", tx8, 1'b1);
    check("rmf idle busy", busy8, 1'b0);
    run_frame("after_rst", 8, 8'h5A, 1'b1, 2'b00, 1'b1);

    // Random frames on both widths
    for (int n = 0; n < 24; n++) begin
      int dw;
      dw = ($urandom_range(0, 1) == 0) ? 5 : 8;
      run_frame($sformatf("rand%0d_dw%0d", n, dw), dw, 8'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer: accepts a parallel word on a valid/busy handshake, computes its parity in one of four modes, and serialises a complete frame onto `TX_OUT`. The frame is start bit, data LSB first, optional parity bit, and 1 or 2 stop bits. It sits in the UART TX path, clocked at the bit rate (one `CLK` cycle per serial bit), and replaces the separate parity/serializer/mux arrangement with one self-contained block.

## Interface
- `DATA_WIDTH`, 8, data bits per frame; legal range 5..9.
- `CLK`  in  1  bit-rate clock, rising-edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH  parallel word to transmit.
- `Data_Valid`  in  1  `P_DATA` and config valid this cycle.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- `STOP2`  in  1  1 = two stop bits, 0 = one.
- `TX_OUT`  out  1  serial line; idle high.
- `Busy`  out  1  frame in progress; new requests ignored.
- `par_bit`  out  1  parity bit of the most recently accepted word (registered).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Acceptance:** in IDLE with `Data_Valid`=1 at a rising edge, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `STOP2` into internal registers.
  - `par_bit` is loaded the same edge: even = ^P_DATA, odd = ~^P_DATA, mark = 1, space = 0.
  - `par_bit` is loaded regardless of `PAR_EN`.
  - FSM goes to START.
- Input changes after acceptance have no effect on the frame in flight. All frame content comes from the latched copies.
- **START:** `TX_OUT`=0 for one cycle, then DATA. The bit counter is cleared.
- **DATA:** `TX_OUT` = latched data[cnt] for DATA_WIDTH cycles, cnt 0..DATA_WIDTH-1, LSB first. The counter is $clog2(DATA_WIDTH) bits wide and does not wrap within a frame.
  - On cnt = DATA_WIDTH-1: go to PARITY if latched `PAR_EN`, else STOP.
- **PARITY:** `TX_OUT`=`par_bit` for one cycle, then STOP.
- **STOP:** `TX_OUT`=1 for 1 cycle, or 2 cycles if latched `STOP2`, then IDLE.
- **Frame length:** L = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) cycles.
- `Busy`=1 in every non-IDLE state. `Data_Valid` while `Busy`=1 is ignored (no queueing).
- `TX_OUT` and `Busy` are registered outputs (decoded from next-state), so they never glitch.
- `TX_OUT`=1 in IDLE.

## Timing
- **Reset values:** `TX_OUT`=1, `Busy`=0, `par_bit`=0, state IDLE, counters 0.
- **Reset mid-frame:** asserting `RST` aborts immediately and asynchronously. Outputs take their reset values; no partial frame resumes after release.
- **Request at edge N:** after edge N, `Busy`=1, `TX_OUT`=0 (start bit) and `par_bit` is valid.
- **Frame bits:** data bit i is on the line after edge N+1+i. The last stop bit is on the line after edge N+L-1.
- **End of frame:** after edge N+L, `Busy`=0 and `TX_OUT`=1.
- **Earliest next request:** acceptance at edge N+L+1. The line is therefore guaranteed at least one idle (high) cycle between frames.
- A `Data_Valid` held high continuously produces back-to-back frames with exactly one idle cycle between them.
- `Data_Valid` coinciding with reset release is ignored. Acceptance requires `RST` high at that edge.

## Test plan
- **Even parity, 1 stop:** DW=8, 0xA5, PAR_EN=1, PAR_TYP=00, STOP2=0 -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1; `Busy` high 11 cycles; `par_bit`=0.
- **Odd parity, 2 stops:** same word, PAR_TYP=01, STOP2=1 -> parity bit 1, two stop bits; `Busy` high 12 cycles, then line high.
- **No parity, 2 stops:** PAR_EN=0, STOP2=1, 0xFF -> 0, eight 1s, 1,1; 11 cycles. Mark (10) with 0x00 -> parity bit 1; space (11) with 0xFF -> parity bit 0.
- **Narrow instance:** DW=5, 0x13, odd parity -> 0,1,1,0,0,1,0,1 (8 cycles); `par_bit`=0.
- **Handshake:** `Data_Valid` held high with 0x3C, and `P_DATA` changed to 0xC3 mid-frame -> the first frame carries 0x3C unchanged; the second frame starts exactly one idle cycle after the first and carries 0xC3.
- **Reset mid-frame:** `RST` low during DATA bit 3 -> `TX_OUT`=1, `Busy`=0 and `par_bit`=0 without waiting for a clock edge. After release, the next request yields a clean full frame.
